hist_lut_ctrl: RTL



---
 rtl/hist_lut_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hist_lut_ctrl.sv
// rtl/hist_lut_ctrl.sv - histogram-equalisation LUT builder with double-buffered pixel remap
// Builds a 256-entry grey-level table from a cumulative histogram into a shadow bank,
// swaps it in on a vsync rise, and remaps the pixel stream through the active bank.
module hist_lut_ctrl #(
  parameter int IMG_PIX     = 307200,
  parameter int SCALE_SHIFT = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pixel_level_vld,
  input  logic [7:0]  pixel_level_data,
  input  logic [20:0] pixel_cnt_num,
  input  logic        pre_img_vsync,
  input  logic        pre_img_hsync,
  input  logic [7:0]  pre_img_gray,
  output logic        post_img_vsync,
  output logic        post_img_hsync,
  output logic [7:0]  post_img_gray,
  output logic        lut_valid,
  output logic        bank_sel,
  output logic        table_drop
);

  localparam logic [63:0] SCALE = (64'd255 << SCALE_SHIFT) / 64'(IMG_PIX);

  typedef enum logic [1:0] {IDLE, FILL, PEND} state_t;

  state_t      state_q;
  logic [8:0]  wr_cnt_q;
  logic        bank_sel_q, lut_valid_q, table_drop_q, vsync_q;
  logic        wr_en_q, wr_bank_q;
  logic [7:0]  wr_addr_q, wr_data_q;
  logic [7:0]  lut0_q [256];
  logic [7:0]  lut1_q [256];
  logic        s1_vsync_q, s1_hsync_q, s1_bank_q, s1_valid_q;
  logic [7:0]  s1_gray_q;
  logic [63:0] product, scaled;
  logic [7:0]  entry_d, rd_data;
  logic        vsync_rise;

  always_comb begin
    product = 64'(pixel_cnt_num) * SCALE;
    scaled  = product >> SCALE_SHIFT;
    entry_d = (scaled > 64'd255) ? 8'hFF : scaled[7:0];
  end

  assign vsync_rise = pre_img_vsync & ~vsync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_cnt_q     <= 9'd0;
      bank_sel_q   <= 1'b0;
      lut_valid_q  <= 1'b0;
      table_drop_q <= 1'b0;
      vsync_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_bank_q    <= 1'b0;
    end else begin
      vsync_q      <= pre_img_vsync;
      table_drop_q <= 1'b0;
      wr_en_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pixel_level_vld) begin
            wr_en_q   <= 1'b1;
            wr_bank_q <= ~bank_sel_q;
            wr_cnt_q  <= 9'd1;
            state_q   <= FILL;
          end
        end
        FILL: begin
          if (pixel_level_vld) begin
            wr_en_q   <= 1'b1;
            wr_bank_q <= ~bank_sel_q;
            wr_cnt_q  <= wr_cnt_q + 9'd1;
            // A 256th entry that is not level 255 means a malformed table.
            if (wr_cnt_q == 9'd255) begin
              if (pixel_level_data == 8'd255) begin
                state_q <= PEND;
              end else begin
                table_drop_q <= 1'b1;
                wr_cnt_q     <= 9'd0;
                state_q      <= IDLE;
              end
            end
          end else begin
            table_drop_q <= 1'b1;
            wr_cnt_q     <= 9'd0;
            state_q      <= IDLE;
          end
        end
        PEND: begin
          if (vsync_rise) begin
            bank_sel_q  <= ~bank_sel_q;
            lut_valid_q <= 1'b1;
            if (pixel_level_vld) begin
              // Swap wins: the retiring active bank becomes the new shadow.
              wr_en_q   <= 1'b1;
              wr_bank_q <= bank_sel_q;
              wr_cnt_q  <= 9'd1;
              state_q   <= FILL;
            end else begin
              wr_cnt_q <= 9'd0;
              state_q  <= IDLE;
            end
          end else if (pixel_level_vld) begin
            table_drop_q <= 1'b1;
            wr_en_q      <= 1'b1;
            wr_bank_q    <= ~bank_sel_q;
            wr_cnt_q     <= 9'd1;
            state_q      <= FILL;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wr_addr_q <= pixel_level_data;
    wr_data_q <= entry_d;
  end

  // Writes land one edge late so a pixel still in flight reads the old contents.
  always_ff @(posedge clk) begin
    if (wr_en_q && !wr_bank_q) lut0_q[wr_addr_q] <= wr_data_q;
    if (wr_en_q &&  wr_bank_q) lut1_q[wr_addr_q] <= wr_data_q;
  end

  assign rd_data = s1_bank_q ? lut1_q[s1_gray_q] : lut0_q[s1_gray_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vsync_q     <= 1'b0;
      s1_hsync_q     <= 1'b0;
      s1_gray_q      <= 8'd0;
      s1_bank_q      <= 1'b0;
      s1_valid_q     <= 1'b0;
      post_img_vsync <= 1'b0;
      post_img_hsync <= 1'b0;
      post_img_gray  <= 8'd0;
    end else begin
      s1_vsync_q     <= pre_img_vsync;
      s1_hsync_q     <= pre_img_hsync;
      s1_gray_q      <= pre_img_gray;
      s1_bank_q      <= bank_sel_q;
      s1_valid_q     <= lut_valid_q;
      post_img_vsync <= s1_vsync_q;
      post_img_hsync <= s1_hsync_q;
      post_img_gray  <= !s1_hsync_q ? 8'd0 : (s1_valid_q ? rd_data : s1_gray_q);
    end
  end

  assign lut_valid  = lut_valid_q;
  assign bank_sel   = bank_sel_q;
  assign table_drop = table_drop_q;

endmodule
